// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - two-requester round-robin/lock arbiter and command sequencer for a single-port BRAM
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_reqN_valid/write/lock       request handshake and attributes (N = 0, 1)
//   i_reqN_addr, i_reqN_wdata     request address and write data
//   o_reqN_ready                  combinational accept for requester N
//   o_rspN_valid, o_rspN_data     one-cycle read-data pulse for requester N
//   o_mem_addr/write/wdata        registered command to the BRAM
//   i_mem_rdata                   BRAM read data
//   o_busy                        read in flight or lock held
module bram_arbiter #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req0_valid,
  input  logic                  i_req0_write,
  input  logic                  i_req0_lock,
  input  logic [ADDR_WIDTH-1:0] i_req0_addr,
  input  logic [DATA_WIDTH-1:0] i_req0_wdata,
  output logic                  o_req0_ready,
  input  logic                  i_req1_valid,
  input  logic                  i_req1_write,
  input  logic                  i_req1_lock,
  input  logic [ADDR_WIDTH-1:0] i_req1_addr,
  input  logic [DATA_WIDTH-1:0] i_req1_wdata,
  output logic                  o_req1_ready,
  output logic                  o_rsp0_valid,
  output logic [DATA_WIDTH-1:0] o_rsp0_data,
  output logic                  o_rsp1_valid,
  output logic [DATA_WIDTH-1:0] o_rsp1_data,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_write,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   prio_q, prio_d;

  logic grant0, grant1;
  logic accept, acc_id, acc_write, acc_lock;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;

  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_write_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  // Tag pipeline: stage 1 lines up with the command register, stage 2 with
  // the cycle in which the BRAM output holds the read data.
  logic t1_rd_q, t1_id_q, t2_rd_q, t2_id_q;

  logic                  rsp0_valid_q, rsp1_valid_q;
  logic [DATA_WIDTH-1:0] rsp0_data_q, rsp1_data_q;

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && acc_lock) state_d = acc_id ? ST_LOCK1 : ST_LOCK0;
      end
      ST_LOCK0, ST_LOCK1: begin
        // Only the owner can be accepted here, so any accept is the owner's.
        if (accept && !acc_lock) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Locked beats come from the owner, and prio already points away from
    // it, so this leaves prio unchanged while a lock is held.
    prio_d = accept ? !acc_id : prio_q;
  end

  // FSM outputs: grant selection
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req0_valid && i_req1_valid) begin
          grant0 = !prio_q;
          grant1 = prio_q;
        end else begin
          grant0 = i_req0_valid;
          grant1 = i_req1_valid;
        end
      end
      ST_LOCK0: grant0 = 1'b1;
      ST_LOCK1: grant1 = 1'b1;
      default: begin
        grant0 = 1'b0;
        grant1 = 1'b0;
      end
    endcase
  end

  assign o_req0_ready = i_req0_valid && grant0 && !i_rst;
  assign o_req1_ready = i_req1_valid && grant1 && !i_rst;

  assign accept    = o_req0_ready || o_req1_ready;
  assign acc_id    = o_req1_ready;
  assign acc_write = acc_id ? i_req1_write : i_req0_write;
  assign acc_lock  = acc_id ? i_req1_lock  : i_req0_lock;
  assign acc_addr  = acc_id ? i_req1_addr  : i_req0_addr;
  assign acc_wdata = acc_id ? i_req1_wdata : i_req0_wdata;

  // Command stage; address and data hold when idle so the BRAM just re-reads.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem_addr_q  <= '0;
      mem_write_q <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      mem_write_q <= accept && acc_write;
      if (accept) begin
        mem_addr_q  <= acc_addr;
        mem_wdata_q <= acc_wdata;
      end
    end
  end

  // Tag pipeline and response registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      t1_rd_q      <= 1'b0;
      t1_id_q      <= 1'b0;
      t2_rd_q      <= 1'b0;
      t2_id_q      <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      t1_rd_q      <= accept && !acc_write;
      t1_id_q      <= acc_id;
      t2_rd_q      <= t1_rd_q;
      t2_id_q      <= t1_id_q;
      rsp0_valid_q <= t2_rd_q && !t2_id_q;
      rsp1_valid_q <= t2_rd_q && t2_id_q;
      if (t2_rd_q && !t2_id_q) rsp0_data_q <= i_mem_rdata;
      if (t2_rd_q && t2_id_q)  rsp1_data_q <= i_mem_rdata;
    end
  end

  assign o_mem_addr   = mem_addr_q;
  assign o_mem_write  = mem_write_q;
  assign o_mem_wdata  = mem_wdata_q;
  assign o_rsp0_valid = rsp0_valid_q;
  assign o_rsp0_data  = rsp0_data_q;
  assign o_rsp1_valid = rsp1_valid_q;
  assign o_rsp1_data  = rsp1_data_q;
  assign o_busy       = t1_rd_q || t2_rd_q || (state_q != ST_IDLE);

endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - self-checking bench for bram_arbiter with a BRAM model and transaction-level reference
module tb_bram_arbiter;
  localparam int AW = 2;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          v0, w0, l0, v1, w1, l1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic          rdy0, rdy1, rv0, rv1, mem_write, busy;
  logic [DW-1:0] rd0, rd1, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .i_req0_write(w0), .i_req0_lock(l0),
    .i_req0_addr(a0), .i_req0_wdata(d0), .o_req0_ready(rdy0),
    .i_req1_valid(v1), .i_req1_write(w1), .i_req1_lock(l1),
    .i_req1_addr(a1), .i_req1_wdata(d1), .o_req1_ready(rdy1),
    .o_rsp0_valid(rv0), .o_rsp0_data(rd0),
    .o_rsp1_valid(rv1), .o_rsp1_data(rd1),
    .o_mem_addr(mem_addr), .o_mem_write(mem_write), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_busy(busy)
  );

  // Single-port BRAM: write-or-read per cycle, output register holds on writes.
  logic [DW-1:0] bram_mem [0:3] = '{32'd0, 32'd0, 32'd0, 32'd0};
  logic [DW-1:0] bram_q = '0;
  always @(posedge clk) begin
    if (mem_write) bram_mem[mem_addr] <= mem_wdata;
    else           bram_q <= bram_mem[mem_addr];
  end
  assign mem_rdata = bram_q;

  // Reference model: transaction level.
  typedef struct {
    int          due;
    bit          id;
    logic [DW-1:0] data;
  } rsp_t;

  rsp_t          pend[$];
  logic [DW-1:0] shadow [0:3] = '{32'd0, 32'd0, 32'd0, 32'd0};
  int            owner = -1;
  bit            mprio = 1'b0;
  int            edge_n = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  bit            exp_write = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic req0(input bit v, input bit w, input bit l, input int a, input logic [DW-1:0] d);
    v0 = v; w0 = w; l0 = l; a0 = AW'(a); d0 = d;
  endtask

  task automatic req1(input bit v, input bit w, input bit l, input int a, input logic [DW-1:0] d);
    v1 = v; w1 = w; l1 = l; a1 = AW'(a); d1 = d;
  endtask

  // One clock: called with inputs already applied after a falling edge.
  task automatic cycle();
    bit g0, g1, acc, id, wr, lk, ev0, ev1;
    logic [AW-1:0] a;
    logic [DW-1:0] d, ed0, ed1;
    #1;
    g0 = 1'b0; g1 = 1'b0;
    if (!rst) begin
      if (owner == 0)      g0 = v0;
      else if (owner == 1) g1 = v1;
      else if (v0 && v1) begin
        g0 = (mprio == 1'b0);
        g1 = (mprio == 1'b1);
      end else begin
        g0 = v0;
        g1 = v1;
      end
    end
    check_eq("ready0", rdy0, g0);
    check_eq("ready1", rdy1, g1);
    acc = g0 || g1;
    id  = g1;
    wr  = id ? w1 : w0;
    lk  = id ? l1 : l0;
    a   = id ? a1 : a0;
    d   = id ? d1 : d0;

    @(posedge clk);
    edge_n++;
    if (rst) begin
      owner = -1; mprio = 1'b0; pend.delete();
      exp_addr = '0; exp_wdata = '0; exp_write = 1'b0;
    end else begin
      exp_write = acc && wr;
      if (acc) begin
        exp_addr  = a;
        exp_wdata = d;
        if (wr) shadow[a] = d;
        else    pend.push_back('{due: edge_n + 2, id: id, data: shadow[a]});
        if (owner < 0 && lk)          owner = id ? 1 : 0;
        else if (owner >= 0 && !lk)   owner = -1;
        mprio = !id;
      end
    end

    #1;
    check_eq("mem_write", mem_write, exp_write);
    check_eq("mem_addr", mem_addr, exp_addr);
    check_eq("mem_wdata", mem_wdata, exp_wdata);
    ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;
    if (pend.size() > 0 && pend[0].due == edge_n) begin
      if (pend[0].id) begin ev1 = 1'b1; ed1 = pend[0].data; end
      else            begin ev0 = 1'b1; ed0 = pend[0].data; end
      void'(pend.pop_front());
    end
    check_eq("rsp0_valid", rv0, ev0);
    check_eq("rsp1_valid", rv1, ev1);
    if (ev0) check_eq("rsp0_data", rd0, ed0);
    if (ev1) check_eq("rsp1_data", rd1, ed1);
    check_eq("busy", busy, (owner >= 0) || (pend.size() > 0));
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    req0(0, 0, 0, 0, '0);
    req1(0, 0, 0, 0, '0);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1;
    req0(0, 0, 0, 0, '0);
    req1(0, 0, 0, 0, '0);
    @(negedge clk);

    // Reset state, then a read dropped by a reset on the next cycle.
    cycle(); cycle();
    check_eq("rst_rsp0_data", rd0, 0);
    check_eq("rst_rsp1_data", rd1, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    req0(1, 0, 0, 1, '0);
    cycle();
    rst = 1'b1;
    req0(0, 0, 0, 0, '0);
    cycle();
    rst = 1'b0;
    idle_cycles(3);
    check_eq("midrd_busy", busy, 0);

    // Round-robin from reset: prio starts at requester 0.
    req0(1, 0, 0, 0, '0);
    req1(1, 0, 0, 1, '0);
    #1;
    check_eq("rr_first_grant0", rdy0, 1);
    check_eq("rr_first_grant1", rdy1, 0);
    for (int i = 0; i < 6; i++) cycle();
    idle_cycles(3);

    // Single requester write then read, same address.
    req0(1, 1, 0, 2, 32'hA5A5A5A5);
    cycle();
    req0(1, 0, 0, 2, '0);
    cycle();
    idle_cycles(2);
    check_eq("sr_rsp0_valid", rv0, 1);
    check_eq("sr_rsp0_data", rd0, 32'hA5A5A5A5);
    idle_cycles(2);

    // Lock burst by requester 1 with an idle gap; requester 0 waits.
    req1(1, 1, 1, 0, 32'h11110000);
    cycle();
    req0(1, 0, 0, 0, '0);
    req1(1, 1, 1, 1, 32'h11110001);
    cycle();
    req1(0, 0, 0, 0, '0);
    cycle();
    check_eq("lock_gap_busy", busy, 1);
    req1(1, 1, 0, 2, 32'h11110002);
    cycle();
    req1(0, 0, 0, 0, '0);
    #1;
    check_eq("lock_release_grant0", rdy0, 1);
    cycle();
    idle_cycles(3);

    // Write by 0 then read by 1 on the following cycle.
    req0(1, 1, 0, 3, 32'h1);
    cycle();
    req0(0, 0, 0, 0, '0);
    req1(1, 0, 0, 3, '0);
    cycle();
    idle_cycles(2);
    check_eq("raw_rsp1_data", rd1, 32'h1);

    // Idle hold after a write.
    req0(1, 1, 0, 1, 32'hDEADBEEF);
    cycle();
    idle_cycles(5);
    check_eq("hold_mem_addr", mem_addr, 1);
    check_eq("hold_mem_write", mem_write, 0);
    check_eq("hold_busy", busy, 0);

    // Randomized traffic with occasional locks and resets.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      req0($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) < 15, $urandom_range(0, 3), $urandom);
      req1($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) < 15, $urandom_range(0, 3), $urandom);
      cycle();
    end
    rst = 1'b0;
    idle_cycles(4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
